// File: rtl/efpga_pkg.sv
// Shared types for the eFPGA request queue: opcodes, the queued request record and FSM states.
// Request field widths are fixed here, so the top-level DW/TAG_W must match EFPGA_DW/EFPGA_TAG_W.
package efpga_pkg;

  typedef enum logic [1:0] {
    OP_A  = 2'b00,
    OP_B  = 2'b01,
    OP_C  = 2'b10,
    OP_WR = 2'b11
  } efpga_op_e;

  // Delay code that tells the sequencer to wait for the fabric's own done signal.
  localparam logic [3:0] EFPGA_DELAY_DONE = 4'hF;

  localparam int EFPGA_DW    = 32;
  localparam int EFPGA_TAG_W = 5;

  typedef struct packed {
    efpga_op_e               op;
    logic [3:0]              delay;
    logic [EFPGA_DW-1:0]     a;
    logic [EFPGA_DW-1:0]     b;
    logic [EFPGA_TAG_W-1:0]  tag;
  } efpga_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } efpga_state_e;

endpackage

// File: rtl/efpga_req_fifo.sv
// In-order request FIFO. The head stays in place until popped, and a flush can optionally
// preserve the head entry when it is still in flight at the sequencer.
module efpga_req_fifo
  import efpga_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = efpga_req_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  logic keep_head_i,
  input  T     data_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               r_mem [DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW:0]    r_count;

  logic [AW-1:0]  w_rd_next;
  logic [AW-1:0]  w_wr_next;
  logic [AW:0]    w_count_next;
  logic           w_push;
  logic           w_pop;
  logic           w_keep;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

  // A push in the flush cycle is discarded along with the queued entries.
  assign w_push = push_i & ~full_o & ~flush_i;
  assign w_pop  = pop_i & ~empty_o;

  always_comb begin
    w_keep       = 1'b0;
    w_rd_next    = r_rd_ptr + AW'(w_pop);
    w_wr_next    = r_wr_ptr + AW'(w_push);
    w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    if (flush_i) begin
      // Surviving content is at most the in-flight head, unless it is popped this cycle.
      w_keep       = keep_head_i & ~w_pop & ~empty_o;
      w_wr_next    = w_rd_next + AW'(w_keep);
      w_count_next = (AW+1)'(w_keep);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= w_wr_next;
      r_count  <= w_count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/efpga_req_queue.sv
// Issue stage for the eFPGA custom-instruction unit: queues requests, launches them one at a
// time into the sequencer, and returns each tagged result through a valid/ready port.
module efpga_req_queue
  import efpga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = EFPGA_DW,
  parameter int TAG_W = EFPGA_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_operator_i,
  input  logic [3:0]       req_delay_i,
  input  logic [DW-1:0]    req_operand_a_i,
  input  logic [DW-1:0]    req_operand_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             efpga_en_o,
  output logic [1:0]       efpga_operator_o,
  output logic [3:0]       efpga_delay_o,
  output logic [DW-1:0]    efpga_operand_a_o,
  output logic [DW-1:0]    efpga_operand_b_o,
  input  logic             efpga_ready_i,
  input  logic [DW-1:0]    efpga_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DW-1:0]    rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o
);

  efpga_state_e     r_state;
  efpga_state_e     w_state_next;
  efpga_req_t       w_push_req;
  efpga_req_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_launch;
  logic             w_capture;
  logic             w_drop;
  logic             w_in_flight;
  logic             r_discard;
  logic [1:0]       r_op;
  logic [3:0]       r_delay;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [DW-1:0]    r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;

  always_comb begin
    w_push_req       = '0;
    w_push_req.op    = efpga_op_e'(req_operator_i);
    w_push_req.delay = req_delay_i;
    w_push_req.a     = req_operand_a_i;
    w_push_req.b     = req_operand_b_i;
    w_push_req.tag   = req_tag_i;
  end

  assign w_in_flight = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_capture   = (r_state == ST_WAIT) && efpga_ready_i;
  assign w_drop      = r_discard | flush_i;

  efpga_req_fifo #(
    .DEPTH (DEPTH),
    .T     (efpga_req_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (req_valid_i),
    .pop_i       (w_capture),
    .flush_i     (flush_i),
    .keep_head_i (w_in_flight),
    .data_i      (w_push_req),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !flush_i && (!rsp_valid_o || rsp_ready_i)) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (efpga_ready_i) begin
          w_state_next = w_drop ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_launch = (r_state == ST_IDLE) && (w_state_next == ST_ISSUE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_discard    <= 1'b0;
      r_op         <= '0;
      r_delay      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
    end else begin
      r_state <= w_state_next;
      // Launch data is latched once and held until the result comes back.
      if (w_launch) begin
        r_op    <= w_head.op;
        r_delay <= w_head.delay;
        r_a     <= w_head.a;
        r_b     <= w_head.b;
      end
      if (w_capture) begin
        r_discard <= 1'b0;
      end else if (flush_i && w_in_flight) begin
        r_discard <= 1'b1;
      end
      if (w_capture && !w_drop) begin
        r_rsp_result <= efpga_result_i;
        r_rsp_tag    <= w_head.tag;
      end
    end
  end

  assign req_ready_o       = ~w_full;
  assign efpga_en_o        = (r_state == ST_ISSUE);
  assign efpga_operator_o  = r_op;
  assign efpga_delay_o     = r_delay;
  assign efpga_operand_a_o = r_a;
  assign efpga_operand_b_o = r_b;
  assign rsp_valid_o       = (r_state == ST_RESP);
  assign rsp_result_o      = r_rsp_result;
  assign rsp_tag_o         = r_rsp_tag;
  assign busy_o            = ~w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_efpga_req_queue.sv
// Directed bench for efpga_req_queue with a cycle model of the downstream sequencer:
// fixed delay d answers at launch+d+2; delay 4'hF answers after DONE_WAIT cycles.
module tb_efpga_req_queue;

  localparam int DW        = 32;
  localparam int TAG_W     = 5;
  localparam int DONE_WAIT = 10;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [1:0]       req_operator_i = '0;
  logic [3:0]       req_delay_i = '0;
  logic [DW-1:0]    req_operand_a_i = '0;
  logic [DW-1:0]    req_operand_b_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             efpga_en_o;
  logic [1:0]       efpga_operator_o;
  logic [3:0]       efpga_delay_o;
  logic [DW-1:0]    efpga_operand_a_o;
  logic [DW-1:0]    efpga_operand_b_o;
  logic             efpga_ready_i = 1'b0;
  logic [DW-1:0]    efpga_result_i = '0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [DW-1:0]    rsp_result_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             busy_o;

  efpga_req_queue #(.DEPTH(4), .DW(DW), .TAG_W(TAG_W)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_operator_i    (req_operator_i),
    .req_delay_i       (req_delay_i),
    .req_operand_a_i   (req_operand_a_i),
    .req_operand_b_i   (req_operand_b_i),
    .req_tag_i         (req_tag_i),
    .efpga_en_o        (efpga_en_o),
    .efpga_operator_o  (efpga_operator_o),
    .efpga_delay_o     (efpga_delay_o),
    .efpga_operand_a_o (efpga_operand_a_o),
    .efpga_operand_b_o (efpga_operand_b_o),
    .efpga_ready_i     (efpga_ready_i),
    .efpga_result_i    (efpga_result_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_result_o      (rsp_result_o),
    .rsp_tag_o         (rsp_tag_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Sequencer model: result = a + b + op, pulsed for one cycle.
  int            seq_cnt = 0;
  int            en_count = 0;
  logic [DW-1:0] seq_a = '0;
  logic [DW-1:0] seq_b = '0;
  logic [1:0]    seq_op = '0;

  always @(negedge clk_i) begin
    efpga_ready_i  = 1'b0;
    efpga_result_i = 32'hDEAD_BEEF;
    if (rst_i) begin
      seq_cnt = 0;
    end else begin
      if (seq_cnt != 0) begin
        seq_cnt = seq_cnt - 1;
        if (seq_cnt == 0) begin
          efpga_ready_i  = 1'b1;
          efpga_result_i = seq_a + seq_b + 32'(seq_op);
        end
      end
      if (efpga_en_o) begin
        en_count = en_count + 1;
        seq_a    = efpga_operand_a_o;
        seq_b    = efpga_operand_b_o;
        seq_op   = efpga_operator_o;
        seq_cnt  = (efpga_delay_o == 4'hF) ? DONE_WAIT : int'(efpga_delay_o) + 2;
      end
    end
  end

  logic [TAG_W-1:0] rsp_tags[$];
  logic [DW-1:0]    rsp_results[$];

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  // Records the response handshake that completes at the coming edge, then advances one cycle.
  task automatic cycle();
    if (rsp_valid_o && rsp_ready_i) begin
      rsp_tags.push_back(rsp_tag_o);
      rsp_results.push_back(rsp_result_o);
      $display("rsp tag=%0d result=%h", rsp_tag_o, rsp_result_o);
    end
    step();
  endtask

  task automatic set_req(input logic v, input logic [1:0] op, input logic [3:0] d,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TAG_W-1:0] t);
    req_valid_i     = v;
    req_operator_i  = op;
    req_delay_i     = d;
    req_operand_a_i = a;
    req_operand_b_i = b;
    req_tag_i       = t;
  endtask

  task automatic clear_rsp();
    rsp_tags.delete();
    rsp_results.delete();
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++; if (req_ready_o !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready_o); else n_pass++;
    n_checks++; if (efpga_en_o !== 1'b0) $display("FAIL reset_en: got %b expected 0", efpga_en_o); else n_pass++;
    n_checks++; if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
    n_checks++; if ({rsp_result_o, rsp_tag_o} !== '0) $display("FAIL reset_rsp_data: got %h/%h expected 0/0", rsp_result_o, rsp_tag_o); else n_pass++;
    n_checks++; if ({efpga_operator_o, efpga_delay_o, efpga_operand_a_o, efpga_operand_b_o} !== '0)
      $display("FAIL reset_efpga_data: got a=%h b=%h expected 0", efpga_operand_a_o, efpga_operand_b_o); else n_pass++;
    rsp_ready_i = 1'b0;
    rst_i = 1'b0;
    step();
    n_checks++; if ({busy_o, req_ready_o} !== 2'b01) $display("FAIL release_idle: got busy=%b ready=%b expected 0/1", busy_o, req_ready_o); else n_pass++;
  endtask

  task automatic test_single_op();
    int en0;
    clear_rsp();
    en0 = en_count;
    rsp_ready_i = 1'b0;
    set_req(1'b1, 2'b01, 4'd3, 32'h11, 32'h22, 5'd7);
    cycle();
    req_valid_i = 1'b0;
    n_checks++; if ({efpga_en_o, busy_o} !== 2'b01) $display("FAIL single_cycle0: got en=%b busy=%b expected 0/1", efpga_en_o, busy_o); else n_pass++;
    cycle();
    n_checks++; if (efpga_en_o !== 1'b1) $display("FAIL single_en_cycle1: got %b expected 1", efpga_en_o); else n_pass++;
    n_checks++; if ({efpga_operator_o, efpga_delay_o, efpga_operand_a_o} !== {2'b01, 4'd3, 32'h11})
      $display("FAIL single_launch_data: got op=%0d d=%0d a=%h expected 1/3/11", efpga_operator_o, efpga_delay_o, efpga_operand_a_o); else n_pass++;
    for (int k = 2; k <= 6; k++) begin
      cycle();
      n_checks++; if ({efpga_en_o, rsp_valid_o} !== 2'b00)
        $display("FAIL single_wait_c%0d: got en=%b rsp_valid=%b expected 0/0", k, efpga_en_o, rsp_valid_o); else n_pass++;
    end
    cycle();
    n_checks++; if (rsp_valid_o !== 1'b1) $display("FAIL single_rsp_valid_c7: got %b expected 1", rsp_valid_o); else n_pass++;
    n_checks++; if ({rsp_result_o, rsp_tag_o} !== {32'h34, 5'd7})
      $display("FAIL single_rsp_data: got %h/%0d expected 34/7", rsp_result_o, rsp_tag_o); else n_pass++;
    cycle();
    n_checks++; if (rsp_valid_o !== 1'b1) $display("FAIL single_rsp_hold: got %b expected 1", rsp_valid_o); else n_pass++;
    rsp_ready_i = 1'b1;
    cycle();
    n_checks++; if ({rsp_valid_o, busy_o} !== 2'b00) $display("FAIL single_after_accept: got valid=%b busy=%b expected 0/0", rsp_valid_o, busy_o); else n_pass++;
    n_checks++; if (rsp_tags.size() != 1 || en_count - en0 != 1)
      $display("FAIL single_counts: got rsp=%0d en=%0d expected 1/1", rsp_tags.size(), en_count - en0); else n_pass++;
  endtask

  task automatic test_backpressure();
    int en0;
    int accepted;
    clear_rsp();
    en0 = en_count;
    accepted = 0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 2'b00, 4'd1, 32'(10 + i), 32'h0, 5'(10 + i));
      if (req_ready_o) accepted++;
      cycle();
    end
    req_valid_i = 1'b0;
    n_checks++; if (accepted != 4) $display("FAIL bp_accepted: got %0d expected 4", accepted); else n_pass++;
    n_checks++; if (req_ready_o !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", req_ready_o); else n_pass++;
    for (int c = 0; c < 20; c++) cycle();
    n_checks++; if (en_count - en0 != 1) $display("FAIL bp_one_launch: got %0d expected 1", en_count - en0); else n_pass++;
    n_checks++; if (rsp_valid_o !== 1'b1) $display("FAIL bp_rsp_held: got %b expected 1", rsp_valid_o); else n_pass++;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 100 && rsp_tags.size() < 4; c++) cycle();
    for (int c = 0; c < 10; c++) cycle();
    n_checks++; if (rsp_tags.size() != 4 || en_count - en0 != 4)
      $display("FAIL bp_drain_counts: got rsp=%0d en=%0d expected 4/4", rsp_tags.size(), en_count - en0); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i < rsp_tags.size()) begin
        n_checks++; if (rsp_tags[i] !== 5'(10 + i) || rsp_results[i] !== 32'(10 + i))
          $display("FAIL bp_rsp%0d: got %0d/%h expected %0d/%h", i, rsp_tags[i], rsp_results[i], 10 + i, 10 + i); else n_pass++;
      end
    end
  endtask

  task automatic test_done_mode();
    int en0;
    int e_cyc;
    int r_cyc;
    bit stable;
    clear_rsp();
    en0 = en_count;
    e_cyc = -1;
    r_cyc = -1;
    stable = 1'b1;
    rsp_ready_i = 1'b1;
    set_req(1'b1, 2'b11, 4'hF, 32'hA5A5_0000, 32'h0000_1234, 5'd3);
    cycle();
    req_valid_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (efpga_en_o && e_cyc < 0) e_cyc = c;
      if (rsp_valid_o && r_cyc < 0) r_cyc = c;
      if (e_cyc >= 0 && r_cyc < 0) begin
        if ({efpga_operator_o, efpga_delay_o, efpga_operand_a_o, efpga_operand_b_o} !==
            {2'b11, 4'hF, 32'hA5A5_0000, 32'h0000_1234}) stable = 1'b0;
      end
      cycle();
    end
    n_checks++; if (!stable) $display("FAIL done_operands_stable: got unstable expected stable"); else n_pass++;
    n_checks++; if (r_cyc - e_cyc != DONE_WAIT + 1)
      $display("FAIL done_latency: got %0d expected %0d", r_cyc - e_cyc, DONE_WAIT + 1); else n_pass++;
    n_checks++; if (en_count - en0 != 1 || rsp_tags.size() != 1)
      $display("FAIL done_counts: got en=%0d rsp=%0d expected 1/1", en_count - en0, rsp_tags.size()); else n_pass++;
    if (rsp_tags.size() > 0) begin
      n_checks++; if ({rsp_results[0], rsp_tags[0]} !== {32'hA5A5_1237, 5'd3})
        $display("FAIL done_rsp: got %h/%0d expected a5a51237/3", rsp_results[0], rsp_tags[0]); else n_pass++;
    end
  endtask

  task automatic test_flush_wait();
    int en0;
    clear_rsp();
    en0 = en_count;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'b00, 4'd8, 32'(i), 32'h0, 5'(20 + i));
      cycle();
    end
    n_checks++; if (req_ready_o !== 1'b0) $display("FAIL flush_pre_full: got %b expected 0", req_ready_o); else n_pass++;
    set_req(1'b1, 2'b00, 4'd1, 32'h30, 32'h0, 5'd30);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    n_checks++; if ({req_ready_o, busy_o} !== 2'b11)
      $display("FAIL flush_emptied: got ready=%b busy=%b expected 1/1", req_ready_o, busy_o); else n_pass++;
    for (int c = 0; c < 40 && !efpga_ready_i; c++) cycle();
    n_checks++; if (efpga_ready_i !== 1'b1) $display("FAIL flush_seq_ready_seen: got %b expected 1", efpga_ready_i); else n_pass++;
    cycle();
    n_checks++; if ({busy_o, rsp_valid_o} !== 2'b00)
      $display("FAIL flush_after_capture: got busy=%b rsp_valid=%b expected 0/0", busy_o, rsp_valid_o); else n_pass++;
    for (int c = 0; c < 10; c++) cycle();
    n_checks++; if (rsp_tags.size() != 0 || en_count - en0 != 1)
      $display("FAIL flush_no_rsp: got rsp=%0d en=%0d expected 0/1", rsp_tags.size(), en_count - en0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int en0;
    int sent;
    clear_rsp();
    en0 = en_count;
    sent = 0;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 300 && rsp_tags.size() < 8; c++) begin
      set_req(sent < 8, 2'b10, 4'(sent % 3), 32'(sent * 16), 32'h1, 5'(sent));
      if (req_valid_i && req_ready_o) sent++;
      cycle();
    end
    req_valid_i = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    n_checks++; if (rsp_tags.size() != 8 || en_count - en0 != 8)
      $display("FAIL stream_counts: got rsp=%0d en=%0d expected 8/8", rsp_tags.size(), en_count - en0); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (i < rsp_tags.size()) begin
        n_checks++; if (rsp_tags[i] !== 5'(i) || rsp_results[i] !== 32'(i * 16 + 3))
          $display("FAIL stream_rsp%0d: got %0d/%h expected %0d/%h", i, rsp_tags[i], rsp_results[i], i, i * 16 + 3); else n_pass++;
      end
    end
  endtask

  task automatic test_async_reset();
    clear_rsp();
    rsp_ready_i = 1'b1;
    set_req(1'b1, 2'b00, 4'd6, 32'h100, 32'h200, 5'd5);
    cycle();
    req_valid_i = 1'b0;
    cycle();
    cycle();
    cycle();
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++; if ({busy_o, req_ready_o, efpga_en_o, rsp_valid_o} !== 4'b0100)
      $display("FAIL areset_ctrl: got busy=%b ready=%b en=%b valid=%b expected 0/1/0/0", busy_o, req_ready_o, efpga_en_o, rsp_valid_o); else n_pass++;
    n_checks++; if ({efpga_operand_a_o, efpga_operand_b_o} !== '0)
      $display("FAIL areset_data: got a=%h b=%h expected 0/0", efpga_operand_a_o, efpga_operand_b_o); else n_pass++;
    step();
    step();
    rst_i = 1'b0;
    step();
    set_req(1'b1, 2'b01, 4'd2, 32'h5, 32'h6, 5'd9);
    cycle();
    req_valid_i = 1'b0;
    for (int c = 0; c < 30; c++) cycle();
    n_checks++; if (rsp_tags.size() != 1) $display("FAIL areset_rsp_count: got %0d expected 1", rsp_tags.size()); else n_pass++;
    if (rsp_tags.size() > 0) begin
      n_checks++; if ({rsp_results[0], rsp_tags[0]} !== {32'h0C, 5'd9})
        $display("FAIL areset_rsp: got %h/%0d expected c/9", rsp_results[0], rsp_tags[0]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_done_mode();
    test_flush_wait();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
